// File: rtl/pong_input_sched.sv
// Per-frame paddle input scheduler: picks analog or digital source per player,
// commits positions on each vsync rise, and shapes coin requests into a frame-timed pulse.
module pong_input_sched #(
  parameter int unsigned COIN_FRAMES = 4,
  parameter int unsigned DIG_STEP    = 3,
  parameter int unsigned ANA_THRESH  = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vsync,
  input  logic [1:0]  mode_p1,
  input  logic [1:0]  mode_p2,
  input  logic [15:0] analog_0,
  input  logic [15:0] analog_1,
  input  logic [7:0]  paddle_0,
  input  logic [7:0]  paddle_1,
  input  logic [1:0]  dig_up,
  input  logic [1:0]  dig_dn,
  input  logic [3:0]  coin_req,
  output logic [7:0]  paddle1_vpos,
  output logic [7:0]  paddle2_vpos,
  output logic [1:0]  src,
  output logic        coin_sw
);

  localparam logic [7:0] STEP8   = 8'(DIG_STEP);
  localparam logic [8:0] THRESH9 = 9'(ANA_THRESH);
  localparam logic [3:0] FRAMES4 = 4'(COIN_FRAMES);

  typedef enum logic [1:0] {IDLE, PULSE, LOCK} coin_state_t;

  logic vsync_d;
  logic tick;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vsync_d <= 1'b1;
      tick    <= 1'b0;
    end else begin
      vsync_d <= vsync;
      tick    <= vsync & ~vsync_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : gen_player
    logic [1:0]  md;
    logic [15:0] stick;
    logic [7:0]  pad;
    logic        up;
    logic        dn;
    logic [7:0]  ana;
    logic [8:0]  diff;
    logic [8:0]  mag;
    logic        ana_act;
    logic        dig_act;
    logic        src_n;
    logic [7:0]  base;
    logic [8:0]  up_v;
    logic [8:0]  dn_v;
    logic [7:0]  stepped;
    logic [7:0]  pos_n;
    logic [7:0]  vpos_q;
    logic [7:0]  integ_q;
    logic [7:0]  prev_q;
    logic        src_q;

    assign md    = (g == 0) ? mode_p1  : mode_p2;
    assign stick = (g == 0) ? analog_0 : analog_1;
    assign pad   = (g == 0) ? paddle_0 : paddle_1;
    assign up    = dig_up[g];
    assign dn    = dig_dn[g];

    always_comb begin
      ana = pad;
      unique case (md)
        2'd0:    ana = stick[15:8] + 8'h80;
        2'd1:    ana = stick[7:0] + 8'h80;
        2'd2:    ana = stick[7:0] ^ 8'h7F;
        default: ana = pad;
      endcase

      diff    = {1'b0, ana} - {1'b0, prev_q};
      mag     = diff[8] ? (9'd0 - diff) : diff;
      ana_act = (mag >= THRESH9);
      dig_act = up ^ dn;

      src_n = src_q;
      if (dig_act)      src_n = 1'b1;
      else if (ana_act) src_n = 1'b0;

      // On a 0->1 switch the integrator starts from the committed position so the paddle does not jump
      base    = src_q ? integ_q : vpos_q;
      up_v    = {1'b0, base} - {1'b0, STEP8};
      dn_v    = {1'b0, base} + {1'b0, STEP8};
      stepped = base;
      if (dig_act) stepped = up ? (up_v[8] ? 8'h00 : up_v[7:0])
                                : (dn_v[8] ? 8'hFF : dn_v[7:0]);

      pos_n = src_n ? stepped : ana;
    end

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        vpos_q  <= 8'h80;
        integ_q <= 8'h80;
        prev_q  <= 8'h80;
        src_q   <= 1'b0;
      end else if (tick) begin
        vpos_q  <= pos_n;
        integ_q <= pos_n;
        prev_q  <= ana;
        src_q   <= src_n;
      end
    end
  end

  assign paddle1_vpos = gen_player[0].vpos_q;
  assign paddle2_vpos = gen_player[1].vpos_q;
  assign src          = {gen_player[1].src_q, gen_player[0].src_q};

  coin_state_t state_q, state_n;
  logic [3:0]  cnt_q, cnt_n;
  logic        coin_n;
  logic        req;
  logic        req_d;

  assign req = |coin_req;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      coin_sw <= 1'b0;
      req_d   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      coin_sw <= coin_n;
      req_d   <= req;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    coin_n  = coin_sw;
    unique case (state_q)
      IDLE: begin
        if (req & ~req_d) begin
          coin_n  = 1'b1;
          cnt_n   = '0;
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (tick) begin
          cnt_n = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == FRAMES4) begin
            coin_n  = 1'b0;
            state_n = LOCK;
          end
        end
      end
      LOCK: begin
        if (!req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/pong_input_sched.md
Name: pong_input_sched

Overview:
- Per-frame input scheduler in front of the pong core.
- For each player, chooses between an analog source and a digital up/down integrator. Whichever source was most recently active wins.
- Commits both paddle positions once per frame, on the vsync rising edge.
- Sequences the coin/start request lines into one clean, frame-timed coin_sw pulse with re-trigger lockout. Sits between hps_io/keyboard decode and the pong core, all on clk_sys.

Parameters:
- COIN_FRAMES, 4: number of vsync rising edges coin_sw stays high per accepted request (1..15).
- DIG_STEP, 3: integrator step per frame for digital up/down (1..127).
- ANA_THRESH, 4: minimum per-frame change in the selected analog value that counts as analog activity (0..255).

Ports:
- clk_sys  in  1  system clock (7.159 MHz)
- reset  in  1  synchronous, active-high reset
- vsync  in  1  core vsync, active-high; its rising edge is the frame tick
- mode_p1  in  2  P1 control mode: 0=Y, 1=X, 2=Inv-X, 3=Paddle
- mode_p2  in  2  P2 control mode, same encoding
- analog_0  in  16  P1 analog stick {Y[15:8], X[7:0]}, signed
- analog_1  in  16  P2 analog stick, same layout
- paddle_0  in  8  P1 paddle, unsigned
- paddle_1  in  8  P2 paddle, unsigned
- dig_up  in  2  digital up, bit0=P1, bit1=P2
- dig_dn  in  2  digital down, bit0=P1, bit1=P2
- coin_req  in  4  level requests (start/coin keys, OSD reset, button); any bit set = request
- paddle1_vpos  out  8  committed P1 position
- paddle2_vpos  out  8  committed P2 position
- src  out  2  per-player active source: 0=analog, 1=digital
- coin_sw  out  1  coin pulse to core

Behaviour:
- Reset values:
  - paddle1_vpos = paddle2_vpos = 0x80; both integrators = 0x80; src = 0; coin_sw = 0.
  - Coin FSM = IDLE; vsync_d = 1, so a high vsync at reset release is not an edge.
  - ana_prev per player = 0x80.
- Frame tick: tick = vsync & ~vsync_d, registered. All per-frame updates below occur in the cycle after tick is detected; outputs are valid 2 clk_sys cycles after the vsync rise. Outputs hold between ticks.
- Analog value per mode, 8-bit wrap arithmetic:
  - mode 0: Y + 0x80
  - mode 1: X + 0x80
  - mode 2: X ^ 0x7F
  - mode 3: paddle unmodified
  - Sampled only on tick.
- Analog activity: |ana - ana_prev| >= ANA_THRESH, computed as a 9-bit difference. ana_prev updates on every tick.
- Digital activity: dig_up XOR dig_dn at tick time. Up and down together = no activity and no motion.
- Source arbitration on tick, per player independently:
  - Digital active: src <= 1.
  - Else analog active: src <= 0.
  - Else src holds.
  - If both are active in the same tick, digital wins.
- Integrator on tick:
  - Switching 0→1 in this tick: the integrator first loads the current committed vpos, then applies the step in the same tick, so the paddle does not jump.
  - Up: pos - DIG_STEP, saturating at 0x00.
  - Down: pos + DIG_STEP, saturating at 0xFF. Use 9-bit intermediates.
  - While src = 0, the integrator tracks the committed vpos each tick.
- Commit: vpos <= (src_next ? integrator_next : ana).
- Mode change mid-frame has no effect until the next tick. The new mode's analog value is compared against the old ana_prev, which may register as activity; this is intended.
- Coin FSM (states IDLE, PULSE, LOCK; req = |coin_req):
  - IDLE: on a req rising edge (req & ~req_d), coin_sw <= 1, cnt <= 0, go to PULSE. The pulse starts the next cycle, not frame-aligned.
  - PULSE: each tick, cnt++. When cnt reaches COIN_FRAMES, coin_sw <= 0 and go to LOCK. Requests in PULSE are ignored.
  - LOCK: stay while req = 1; go to IDLE in the cycle after req = 0. A request held through the whole pulse yields exactly one pulse.
  - A request that rises and falls within PULSE is lost.
- Reset mid-operation: every register returns to its reset value in the next cycle. coin_sw drops immediately; an in-flight pulse is not completed.
- If vsync is stuck, no ticks occur: positions freeze and the coin pulse stays high until reset. Accepted.

Test Plan:
- Reset, mode_p1=0, analog_0=0x3000, vsync toggled → after first tick: paddle1_vpos=0xB0, src[0]=0. Before any tick: 0x80.
- Modes 1/2/3 with analog_0=0x00F0, paddle_0=0x55 → vpos 0x70 / 0x8F / 0x55 respectively after one tick each.
- P1 at 0xB0 analog; hold dig_up[0] for 3 ticks, DIG_STEP=3 → src[0]=1; vpos 0xAD, 0xAA, 0xA7 (no jump). Release, then analog change ≥4 → src[0]=0.
- Saturation: integrator 0x01, dig_up held → 0x00 and stays. Integrator 0xFE, dig_dn held → 0xFF. dig_up=dig_dn=1 → no change, src holds.
- Same tick digital press and analog delta 0x40 → src=1. Analog delta of 3 (below ANA_THRESH=4) with no digital input → src unchanged.
- coin_req[2] held 10 frames, COIN_FRAMES=4 → coin_sw high for exactly 4 ticks, one pulse, no re-trigger until release then re-press. Reset asserted during PULSE → coin_sw=0 the next cycle.
